// File: rtl/draw_pkg.sv
// Shared constants for the draw dispatcher: engine opcodes and the dispatcher FSM encoding.
package draw_pkg;

    localparam int OP_CLEAR    = 0;
    localparam int OP_TRIANGLE = 1;
    localparam int OP_RECT     = 2;
    localparam int OP_LINE     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } draw_state_t;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Show-ahead command queue; dout always presents the oldest entry while not empty.
module draw_cmd_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/draw_dispatch.sv
// Queues draw commands and launches them one at a time on the engine named by the opcode.
// Optional macro DRAW_DISPATCH_STATS_EN builds a saturating completed-command counter.
module draw_dispatch
    import draw_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int OPCODE_WIDTH = 3,
    parameter int NUM_OPS      = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [OPCODE_WIDTH-1:0]         cmd_opcode,
    input  logic [WIDTH-1:0]                cmd_ax,
    input  logic [WIDTH-1:0]                cmd_ay,
    input  logic [WIDTH-1:0]                cmd_bx,
    input  logic [WIDTH-1:0]                cmd_by,
    input  logic [WIDTH-1:0]                cmd_cx,
    input  logic [WIDTH-1:0]                cmd_cy,
    input  logic [COLOUR_WIDTH-1:0]         cmd_colour,
    output logic [NUM_OPS-1:0]              eng_start,
    input  logic [NUM_OPS-1:0]              eng_done,
    output logic [WIDTH-1:0]                eng_ax,
    output logic [WIDTH-1:0]                eng_ay,
    output logic [WIDTH-1:0]                eng_bx,
    output logic [WIDTH-1:0]                eng_by,
    output logic [WIDTH-1:0]                eng_cx,
    output logic [WIDTH-1:0]                eng_cy,
    output logic [COLOUR_WIDTH-1:0]         eng_colour,
    input  logic [NUM_OPS-1:0]              eng_screen_start,
    input  logic [NUM_OPS*COLOUR_WIDTH-1:0] eng_new_colour,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_x_min,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_y_min,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_x_range,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_y_range,
    output logic                            screen_start,
    output logic [COLOUR_WIDTH-1:0]         new_screen_colour,
    output logic [WIDTH-1:0]                screen_x_min,
    output logic [WIDTH-1:0]                screen_y_min,
    output logic [WIDTH-1:0]                screen_x_range,
    output logic [WIDTH-1:0]                screen_y_range,
    output logic                            busy,
    output logic                            cmd_done,
    output logic                            err_illegal,
    input  logic                            err_clear,
    output logic [15:0]                     cmd_count,
    output draw_state_t                     fsm_state
);

    localparam int PAYLOAD_W = OPCODE_WIDTH + 6*WIDTH + COLOUR_WIDTH;
    localparam logic [OPCODE_WIDTH:0] NUM_OPS_W = (OPCODE_WIDTH+1)'(NUM_OPS);

    draw_state_t              state;
    draw_state_t              state_next;
    logic [OPCODE_WIDTH-1:0]  sel;
    logic                     sel_legal;
    logic                     sel_done;
    logic                     pop;
    logic                     launch_illegal;
    logic                     finish;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [PAYLOAD_W-1:0]     fifo_din;
    logic [PAYLOAD_W-1:0]     fifo_dout;
    logic [OPCODE_WIDTH-1:0]  head_opcode;
    logic [WIDTH-1:0]         head_ax, head_ay, head_bx, head_by, head_cx, head_cy;
    logic [COLOUR_WIDTH-1:0]  head_colour;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both
    // high; cmd_ready depends only on queue occupancy, never on cmd_valid.
    assign cmd_ready = !fifo_full;
    assign fifo_din  = {cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy, cmd_colour};
    assign {head_opcode, head_ax, head_ay, head_bx, head_by, head_cx, head_cy, head_colour} = fifo_dout;

    draw_cmd_fifo #(
        .DATA_WIDTH (PAYLOAD_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sel_legal = {1'b0, sel} < NUM_OPS_W;

    always_comb begin
        sel_done = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (sel == OPCODE_WIDTH'(i)) sel_done = eng_done[i];
        end
    end

    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        launch_illegal = 1'b0;
        finish         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (sel_legal) begin
                    state_next = ST_WAIT;
                end else begin
                    launch_illegal = 1'b1;
                    finish         = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sel_done) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel         <= '0;
            eng_ax      <= '0;
            eng_ay      <= '0;
            eng_bx      <= '0;
            eng_by      <= '0;
            eng_cx      <= '0;
            eng_cy      <= '0;
            eng_colour  <= '0;
            cmd_done    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state    <= state_next;
            cmd_done <= finish;
            // Operands only change when the next command is popped, so they hold through done.
            if (pop) begin
                sel        <= head_opcode;
                eng_ax     <= head_ax;
                eng_ay     <= head_ay;
                eng_bx     <= head_bx;
                eng_by     <= head_by;
                eng_cx     <= head_cx;
                eng_cy     <= head_cy;
                eng_colour <= head_colour;
            end
            if (launch_illegal)  err_illegal <= 1'b1;
            else if (err_clear)  err_illegal <= 1'b0;
        end
    end

    // An illegal sel matches no engine index, so start and screen mux stay zero for it.
    always_comb begin
        eng_start         = '0;
        screen_start      = 1'b0;
        new_screen_colour = '0;
        screen_x_min      = '0;
        screen_y_min      = '0;
        screen_x_range    = '0;
        screen_y_range    = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (state == ST_LAUNCH && sel == OPCODE_WIDTH'(i)) eng_start[i] = 1'b1;
            if (state != ST_IDLE && sel == OPCODE_WIDTH'(i)) begin
                screen_start      = eng_screen_start[i];
                new_screen_colour = eng_new_colour[i*COLOUR_WIDTH +: COLOUR_WIDTH];
                screen_x_min      = eng_x_min[i*WIDTH +: WIDTH];
                screen_y_min      = eng_y_min[i*WIDTH +: WIDTH];
                screen_x_range    = eng_x_range[i*WIDTH +: WIDTH];
                screen_y_range    = eng_y_range[i*WIDTH +: WIDTH];
            end
        end
    end

    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign fsm_state = state;

`ifdef DRAW_DISPATCH_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clock) begin
        if (reset)                                 count_q <= '0;
        else if (cmd_done && count_q != 16'hFFFF)  count_q <= count_q + 16'd1;
    end

    assign cmd_count = count_q;
`else
    assign cmd_count = '0;
`endif

endmodule

// File: doc/draw_dispatch.md
DRAW_DISPATCH -- requirements
Module: draw_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, coordinate width in bits.
REQ-002 SHALL have parameter COLOUR_WIDTH, default 3, pixel colour width in bits.
REQ-003 SHALL have parameter OPCODE_WIDTH, default 3, opcode width in bits.
REQ-004 SHALL have parameter NUM_OPS, default 4, number of attached draw engines (2..2**OPCODE_WIDTH).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-006 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake; transfer when both are high.
REQ-009 SHALL have ports cmd_opcode (input, OPCODE_WIDTH), cmd_ax/ay/bx/by/cx/cy (input, WIDTH each) and cmd_colour (input, COLOUR_WIDTH): command payload.
REQ-010 SHALL have ports eng_start (output, NUM_OPS, one-hot start pulse) and eng_done (input, NUM_OPS, per-engine done pulse).
REQ-011 SHALL have ports eng_ax..eng_cy (output, WIDTH each) and eng_colour (output, COLOUR_WIDTH): latched operands shared by all engines.
REQ-012 SHALL have packed per-engine screen buses as inputs: eng_screen_start (NUM_OPS), eng_new_colour (NUM_OPS*COLOUR_WIDTH), eng_x_min/eng_y_min/eng_x_range/eng_y_range (NUM_OPS*WIDTH each).
REQ-013 SHALL have outputs screen_start (1), new_screen_colour (COLOUR_WIDTH), and screen_x_min/screen_y_min/screen_x_range/screen_y_range (WIDTH each): muxed to the pixel interface.
REQ-014 SHALL have outputs busy (1), cmd_done (1, one-cycle pulse), err_illegal (1, sticky), and input err_clear (1).
REQ-015 SHALL have output cmd_count (16): count of completed commands.

Function
REQ-016 Commands SHALL be queued in a FIFO_DEPTH-entry FIFO; cmd_ready = not full; a push while full SHALL NOT occur; a push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-017 The FSM SHALL have states IDLE, LAUNCH and WAIT.
REQ-018 IDLE SHALL move to LAUNCH when the FIFO is non-empty; the transition pops the head and latches the opcode into sel and the operands into eng_*.
REQ-019 In LAUNCH, a legal opcode (< NUM_OPS) SHALL assert eng_start[sel] for exactly one cycle and then move to WAIT.
REQ-020 In LAUNCH, an illegal opcode SHALL set err_illegal, issue no eng_start, pulse cmd_done and return to IDLE.
REQ-021 In WAIT, eng_done[sel] SHALL pulse cmd_done for one cycle and return to IDLE; eng_done bits other than sel SHALL be ignored.
REQ-022 Latency: for a command accepted into an empty FIFO at edge N, eng_start SHALL be high in the cycle after edge N+1.
REQ-023 Back-to-back: the next command SHALL launch no earlier than one IDLE cycle after cmd_done.
REQ-024 eng_* operands SHALL stay stable from LAUNCH until the cycle after done.
REQ-025 Screen outputs SHALL select engine sel from the registered sel only, never from cmd_opcode.
REQ-026 Screen outputs SHALL be all-zero in IDLE and for an illegal opcode.
REQ-027 busy SHALL be high when the state is not IDLE or the FIFO is non-empty.
REQ-028 err_clear SHALL clear err_illegal; if it coincides with a new illegal opcode, the set SHALL win.

Reset
REQ-029 Reset SHALL empty the FIFO and set state IDLE, sel 0, eng_start 0, cmd_done 0, err_illegal 0, cmd_count 0 and eng_* 0.
REQ-030 Reset during WAIT SHALL abandon the command without cmd_done; engines SHALL be reset by the same signal.

Configuration
REQ-031 With DRAW_DISPATCH_STATS_EN defined, cmd_count SHALL increment on every cmd_done and saturate at 16'hFFFF.
REQ-032 Without DRAW_DISPATCH_STATS_EN, cmd_count SHALL be constant 0 and no counter SHALL be built.

Structure
REQ-033 Opcode constants OP_CLEAR=0, OP_TRIANGLE=1, OP_RECT=2 and OP_LINE=3, and the FSM state encoding, SHALL reside in the shared package draw_pkg.
REQ-034 The queue SHALL be the sub-module draw_cmd_fifo (parameters for width and depth; push, pop, full, empty).

Verification
REQ-035 Triangle (opcode 1, colour 3'b101) into an empty queue -> eng_start = 4'b0010 two cycles after accept; cmd_done one cycle after eng_done[1].
REQ-036 Five commands pushed while engine 0 stalls, with FIFO_DEPTH=4 -> cmd_ready low after the 4th queued entry; all five complete in order.
REQ-037 Opcode 6 with NUM_OPS=4 -> err_illegal=1, no eng_start, cmd_done pulses, screen outputs zero; err_clear -> err_illegal=0.
REQ-038 eng_done[2] asserted while sel=1 in WAIT -> ignored; FSM stays in WAIT.
REQ-039 Reset asserted in WAIT -> next cycle busy=0, cmd_ready=1, no cmd_done.
REQ-040 With DRAW_DISPATCH_STATS_EN, 3 completed commands -> cmd_count=3; without the macro -> cmd_count=0.
